uscope_dma_writer: RTL and testbench
====================================

# uscope_dma_writer

Buffer-capture stage directly downstream of the uScope acquisition core. Consumes the core's packed 32-bit sample stream and writes each beat to a memory buffer through single-beat AXI-lite write transactions. Reports completion to the core via a one-cycle `dma_done` pulse, so the core can re-arm its trigger.

## Interface
- `DATA_WIDTH`, 32: stream and AXI data width; only 32 is supported.
- `ADDR_WIDTH`, 32: AXI address width.
- `COUNT_WIDTH`, 16: width of the sample counters.
- `clock` in 1: single clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `arm` in 1: single-cycle start of a capture buffer; ignored unless the FSM is in IDLE.
- `buffer_base` in ADDR_WIDTH: buffer byte address, latched on `arm`; bits [1:0] are forced to 0.
- `n_samples` in COUNT_WIDTH: buffer length in beats, latched on `arm`.
- `data_in` axi_stream.slave: sample stream; uses `data`, `valid`, `ready`, `tlast`; `dest` is ignored.
- `axi_out` axi_lite.master: write channels AW/W/B only; AR and R are tied inactive.
- `dma_done` out 1: one-cycle pulse at the end of each buffer.
- `busy` out 1: high in every state except IDLE.
- `samples_written` out COUNT_WIDTH: number of beats acknowledged in the current or last buffer.
- `bus_error` out 1: sticky; set on `BRESP != 0`, cleared on the next accepted `arm`.

## Operation
- States:
  - IDLE: the block waits for a valid `arm`.
  - WAIT_DATA: `data_in.ready=1`.
  - WRITE: `AWVALID` and `WVALID` asserted.
  - RESP: `BREADY=1`.
  - DONE: the `dma_done` cycle.
- IDLE -> WAIT_DATA on `arm` with `n_samples != 0`. The block latches base and length, and clears `count`, `samples_written` and `bus_error`.
- An `arm` with `n_samples == 0` is ignored: the block stays in IDLE and every output is unchanged.
- WAIT_DATA -> WRITE on `valid & ready`. The block registers the beat and its `tlast`.
- WRITE:
  - `AWADDR = base + 4*count`, `WDATA = beat`, `WSTRB = 4'hF`, `AWPROT = 0`.
  - `AWVALID` drops after its own handshake and `WVALID` drops after its own; the two are independent and may complete in either order or in the same cycle.
  - Once both channels have handshaked, the FSM moves to RESP.
- RESP -> on `BVALID`:
  - `samples_written` and `count` each increment by 1.
  - If `BRESP != 0`, `bus_error` is set; the block continues the buffer regardless.
  - If `count + 1 == n_samples` or the registered `tlast` is set, the FSM moves to DONE; otherwise it returns to WAIT_DATA.
- DONE -> IDLE after exactly one cycle with `dma_done=1`.
- A `tlast` before `n_samples` ends the buffer early; `samples_written` holds the short count.
- Beats beyond `n_samples` are not accepted: `ready=0` outside WAIT_DATA.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not flagged.
- `arm` while busy is ignored; it is neither queued nor allowed to restart the buffer.

## Timing
- Reset values: state IDLE. Outputs `dma_done`, `busy`, `bus_error`, `data_in.ready`, `AWVALID`, `WVALID`, `BREADY` are 0. `samples_written` is 0 and `AWADDR`/`WDATA` are 0.
- Reset mid-transaction takes effect asynchronously and drops all valids immediately. No AXI completion is awaited.
- Sequence, with `AWREADY`, `WREADY` and `BVALID` always 1:
  - beat accepted on edge N;
  - `AWVALID`/`WVALID` high in cycle N+1;
  - handshake on edge N+1;
  - `BREADY` high in cycle N+2, response on edge N+2;
  - `ready` high again in cycle N+3.
- Peak throughput is therefore 1 beat per 3 cycles.
- Once asserted, `AWVALID`/`WVALID` and their payloads stay stable until the corresponding ready; no combinational ready-to-valid paths.
- `dma_done` is high in the cycle after the last `BVALID` handshake.
- `busy` is low in the cycle after that (the IDLE cycle), so re-arming is possible no earlier than 2 cycles after the final response.

## Structure
- Shared package `uscope_dma_pkg`:
  - state enum `dma_wr_state_t`;
  - `ADDR_STRIDE = 4`;
  - `BRESP_OKAY = 2'b00`.
- One sub-module, `uscope_dma_write_channel`, owns the AW/W valid-hold flags and the two handshake-complete flags. It returns `write_accepted` once both channels have handshaked.
- The top level holds the FSM, counters, latched configuration and `bus_error`.

## Test plan
- **Basic buffer:** arm, base `0x3F000000`, n=4, 4 beats with ready-always slave.
  - Writes go to `0x3F000000`, `0x3F000004`, `0x3F000008`, `0x3F00000C` with matching data.
  - `dma_done` pulses once; `samples_written=4`.
- **Early `tlast`:** n=64, `tlast` on beat 3.
  - Exactly 3 writes; `dma_done` after the third `BVALID`; `samples_written=3`.
- **Decoupled handshakes:** `WREADY` 2 cycles before `AWREADY`, then the reverse.
  - Both orders complete; `WVALID` deasserts after its own handshake; no duplicate writes.
- **Slave error response:** `BRESP=2'b10` on beat 2 of 4.
  - All 4 writes issued; `bus_error=1` persists until the next accepted `arm`.
- **Illegal/ignored arms:** `arm` with n=0, and `arm` while busy.
  - No state change, no writes, `busy` unaffected.
- **Reset mid-transaction:** assert `reset` while `AWVALID=1`.
  - `AWVALID`, `WVALID`, `BREADY`, `busy` go to 0 immediately.
  - After release, a new n=2 buffer writes from `base+0`.

Source files
------------

// File: rtl/uscope_dma_pkg.sv
// Shared types and constants for the uScope capture DMA writer.
package uscope_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_WRITE     = 3'd2,
        ST_RESP      = 3'd3,
        ST_DONE      = 3'd4
    } dma_wr_state_t;

    localparam int unsigned ADDR_STRIDE = 4;
    localparam logic [1:0]  BRESP_OKAY  = 2'b00;

endpackage

// File: rtl/uscope_dma_write_channel.sv
// AXI-lite AW/W issue tracking: holds each valid until its own handshake and
// reports write_accepted once both address and data have been taken.
module uscope_dma_write_channel (
    input  logic clock_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic write_accepted_o
);

    logic aw_pend_q, aw_pend_d;
    logic w_pend_q,  w_pend_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic aw_hs, w_hs;

    assign aw_hs     = aw_pend_q & awready_i;
    assign w_hs      = w_pend_q & wready_i;
    assign awvalid_o = aw_pend_q;
    assign wvalid_o  = w_pend_q;

    // The channels may finish in either order; a handshake in the current
    // cycle counts so the FSM can leave WRITE on the completing edge.
    assign write_accepted_o = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (start_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_pend_d = 1'b0;
                aw_done_d = 1'b1;
            end
            if (w_hs) begin
                w_pend_d = 1'b0;
                w_done_d = 1'b1;
            end
            if (write_accepted_o) begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: rtl/uscope_dma_writer.sv
// Capture-buffer writer: turns the acquisition sample stream into single-beat
// AXI-lite writes at base + 4*index and pulses dma_done at end of buffer.
module uscope_dma_writer
    import uscope_dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      arm_i,
    input  logic [ADDR_WIDTH-1:0]     buffer_base_i,
    input  logic [COUNT_WIDTH-1:0]    n_samples_i,
    input  logic [DATA_WIDTH-1:0]     s_data_i,
    input  logic                      s_valid_i,
    input  logic                      s_tlast_i,
    output logic                      s_ready_o,
    output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
    output logic [2:0]                m_awprot_o,
    output logic                      m_awvalid_o,
    input  logic                      m_awready_i,
    output logic [DATA_WIDTH-1:0]     m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
    output logic                      m_wvalid_o,
    input  logic                      m_wready_i,
    input  logic [1:0]                m_bresp_i,
    input  logic                      m_bvalid_i,
    output logic                      m_bready_o,
    output logic [ADDR_WIDTH-1:0]     m_araddr_o,
    output logic [2:0]                m_arprot_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [DATA_WIDTH-1:0]     m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o,
    output logic                      dma_done_o,
    output logic                      busy_o,
    output logic [COUNT_WIDTH-1:0]    samples_written_o,
    output logic                      bus_error_o
);

    dma_wr_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [COUNT_WIDTH-1:0] n_q, n_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  beat_q, beat_d;
    logic                   tlast_q, tlast_d;
    logic                   bus_error_q, bus_error_d;
    logic                   start_write;
    logic                   write_accepted;
    logic                   unused_read_side;

    // Read channels are never used by this block.
    assign unused_read_side = ^{m_arready_i, m_rdata_i, m_rresp_i, m_rvalid_i};
    assign m_araddr_o  = '0;
    assign m_arprot_o  = '0;
    assign m_arvalid_o = 1'b0;
    assign m_rready_o  = 1'b0;

    uscope_dma_write_channel u_write_channel (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_write),
        .awready_i        (m_awready_i),
        .wready_i         (m_wready_i),
        .awvalid_o        (m_awvalid_o),
        .wvalid_o         (m_wvalid_o),
        .write_accepted_o (write_accepted)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        count_d     = count_q;
        beat_d      = beat_q;
        tlast_d     = tlast_q;
        bus_error_d = bus_error_q;
        start_write = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arm_i && (n_samples_i != '0)) begin
                    state_d     = ST_WAIT_DATA;
                    base_d      = {buffer_base_i[ADDR_WIDTH-1:2], 2'b00};
                    n_d         = n_samples_i;
                    count_d     = '0;
                    bus_error_d = 1'b0;
                end
            end
            ST_WAIT_DATA: begin
                if (s_valid_i) begin
                    beat_d      = s_data_i;
                    tlast_d     = s_tlast_i;
                    start_write = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (write_accepted) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_bvalid_i) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                    if (m_bresp_i != BRESP_OKAY) begin
                        bus_error_d = 1'b1;
                    end
                    if ((count_d == n_q) || tlast_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            n_q         <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            tlast_q     <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            tlast_q     <= tlast_d;
            bus_error_q <= bus_error_d;
        end
    end

    // count only advances on a B handshake, so it doubles as samples_written.
    assign samples_written_o = count_q;
    assign bus_error_o       = bus_error_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign s_ready_o         = (state_q == ST_WAIT_DATA);
    assign m_bready_o        = (state_q == ST_RESP);
    assign dma_done_o        = (state_q == ST_DONE);
    assign m_awaddr_o        = base_q + (ADDR_WIDTH'(count_q) * ADDR_WIDTH'(ADDR_STRIDE));
    assign m_awprot_o        = 3'b000;
    assign m_wdata_o         = beat_q;
    assign m_wstrb_o         = '1;

endmodule

// File: tb/tb_uscope_dma_writer.sv
// Scoreboard bench for uscope_dma_writer: directed buffers push expected
// writes/completions, a negedge monitor pops and compares them.
module tb_uscope_dma_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [31:0] buffer_base;
    logic [15:0] n_samples;
    logic [31:0] s_data;
    logic        s_valid, s_tlast, s_ready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, rready;
    logic        dma_done, busy, bus_error;
    logic [15:0] samples_written;

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int aw_delay = 0;
    int w_delay  = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int b_idx    = 0;
    int err_idx  = -1;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_done[$];
    int          done_seen = 0;
    int          done_expected = 0;
    logic [31:0] cur_base;
    int          idx;
    bit          aw_prev = 0;
    bit          w_prev  = 0;

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign bvalid  = 1'b1;
    assign bresp   = (b_idx == err_idx) ? 2'b10 : 2'b00;

    uscope_dma_writer dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .arm_i             (arm),
        .buffer_base_i     (buffer_base),
        .n_samples_i       (n_samples),
        .s_data_i          (s_data),
        .s_valid_i         (s_valid),
        .s_tlast_i         (s_tlast),
        .s_ready_o         (s_ready),
        .m_awaddr_o        (awaddr),
        .m_awprot_o        (awprot),
        .m_awvalid_o       (awvalid),
        .m_awready_i       (awready),
        .m_wdata_o         (wdata),
        .m_wstrb_o         (wstrb),
        .m_wvalid_o        (wvalid),
        .m_wready_i        (wready),
        .m_bresp_i         (bresp),
        .m_bvalid_i        (bvalid),
        .m_bready_o        (bready),
        .m_araddr_o        (araddr),
        .m_arprot_o        (arprot),
        .m_arvalid_o       (arvalid),
        .m_arready_i       (1'b0),
        .m_rdata_i         (32'h0),
        .m_rresp_i         (2'b00),
        .m_rvalid_i        (1'b0),
        .m_rready_o        (rready),
        .dma_done_o        (dma_done),
        .busy_o            (busy),
        .samples_written_o (samples_written),
        .bus_error_o       (bus_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic failure(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none / timeout", name);
    endtask

    // Slave wait counters advance on the clock edge so the DUT sees a stable ready.
    always @(posedge clk) begin
        aw_cnt <= (!awvalid || awready) ? 0 : aw_cnt + 1;
        w_cnt  <= (!wvalid || wready) ? 0 : w_cnt + 1;
        if (bvalid && bready) b_idx <= b_idx + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            aw_prev = 0;
            w_prev  = 0;
        end else begin
            if (aw_prev) check("awvalid_drop", awvalid, 0);
            if (w_prev)  check("wvalid_drop", wvalid, 0);
            aw_prev = awvalid && awready;
            w_prev  = wvalid && wready;
            if (awvalid && awready) begin
                if (exp_addr.size() == 0) failure("unexpected_aw");
                else check("awaddr", awaddr, exp_addr.pop_front());
                check("awprot", awprot, 0);
            end
            if (wvalid && wready) begin
                if (exp_data.size() == 0) failure("unexpected_w");
                else check("wdata", wdata, exp_data.pop_front());
                check("wstrb", wstrb, 4'hF);
            end
            if (dma_done) begin
                done_seen++;
                if (exp_done.size() == 0) failure("unexpected_done");
                else check("samples_at_done", samples_written, exp_done.pop_front());
            end
        end
    end

    task automatic do_arm(input logic [31:0] base, input logic [15:0] n, input bit model);
        arm = 1'b1;
        buffer_base = base;
        n_samples = n;
        @(posedge clk);
        #1;
        arm = 1'b0;
        if (model) begin
            cur_base = base & 32'hFFFF_FFFC;
            idx = 0;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        @(posedge clk);
        #1;
        s_data  = d;
        s_tlast = last;
        s_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                s_tlast = 1'b0;
                return;
            end
        end
        failure("send_timeout");
        s_valid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] d, input logic last);
        exp_addr.push_back(cur_base + 32'(4 * idx));
        exp_data.push_back(d);
        idx++;
        send_beat(d, last);
    endtask

    task automatic expect_done(input int n);
        exp_done.push_back(n);
        done_expected++;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        failure("idle_timeout");
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; buffer_base = '0; n_samples = '0;
        s_data = '0; s_valid = 1'b0; s_tlast = 1'b0;
        cur_base = '0; idx = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", s_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_done", dma_done, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_samples", samples_written, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);

        // Basic buffer with latency checks on the first beat.
        do_arm(32'h3F00_0000, 16'd4, 1);
        expect_done(4);
        send_exp(32'hA500_0000, 1'b0);
        @(negedge clk);
        check("lat_awvalid_n1", awvalid, 1);
        check("lat_wvalid_n1", wvalid, 1);
        @(negedge clk);
        check("lat_bready_n2", bready, 1);
        check("lat_awvalid_n2", awvalid, 0);
        @(negedge clk);
        check("lat_ready_n3", s_ready, 1);
        for (int i = 1; i < 4; i++) send_exp(32'hA500_0000 + 32'(i), 1'b0);
        wait_idle();
        check("basic_samples", samples_written, 4);
        check("basic_done_count", done_seen, 1);

        // Early tlast on the third beat.
        do_arm(32'h1000_0010, 16'd64, 1);
        expect_done(3);
        send_exp(32'h1111_0001, 1'b0);
        send_exp(32'h1111_0002, 1'b0);
        send_exp(32'h1111_0003, 1'b1);
        wait_idle();
        check("tlast_samples", samples_written, 3);

        // Decoupled handshakes, both orders.
        aw_delay = 2; w_delay = 0;
        do_arm(32'h2000_0000, 16'd2, 1);
        expect_done(2);
        send_exp(32'h2222_0000, 1'b0);
        send_exp(32'h2222_0001, 1'b0);
        wait_idle();
        aw_delay = 0; w_delay = 2;
        do_arm(32'h2000_1003, 16'd2, 1);
        expect_done(2);
        send_exp(32'h3333_0000, 1'b0);
        send_exp(32'h3333_0001, 1'b0);
        wait_idle();
        w_delay = 0;
        check("decoupled_samples", samples_written, 2);

        // Error response on the second beat of four.
        err_idx = b_idx + 1;
        do_arm(32'h3000_0000, 16'd4, 1);
        expect_done(4);
        for (int i = 0; i < 4; i++) send_exp(32'h4444_0000 + 32'(i), 1'b0);
        wait_idle();
        err_idx = -1;
        check("err_bus_error", bus_error, 1);
        check("err_samples", samples_written, 4);

        // arm with n=0 is ignored.
        do_arm(32'h4000_0000, 16'd0, 0);
        @(negedge clk);
        check("zero_arm_busy", busy, 0);
        check("zero_arm_bus_error", bus_error, 1);
        check("zero_arm_samples", samples_written, 4);

        // Accepted arm clears bus_error; arm while busy is ignored.
        do_arm(32'h5000_0004, 16'd3, 1);
        @(negedge clk);
        check("rearm_bus_error", bus_error, 0);
        check("rearm_busy", busy, 1);
        check("rearm_samples", samples_written, 0);
        expect_done(3);
        send_exp(32'h5555_0000, 1'b0);
        do_arm(32'h6000_0000, 16'd8, 0);
        @(negedge clk);
        check("busy_arm_busy", busy, 1);
        send_exp(32'h5555_0001, 1'b0);
        send_exp(32'h5555_0002, 1'b0);
        wait_idle();
        check("busy_arm_samples", samples_written, 3);

        // Reset while AWVALID is held by a slow slave.
        aw_delay = 5; w_delay = 5;
        do_arm(32'h7000_0000, 16'd4, 1);
        send_beat(32'h7777_0000, 1'b0);
        @(negedge clk);
        check("pre_reset_awvalid", awvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("reset_awvalid", awvalid, 0);
        check("reset_wvalid", wvalid, 0);
        check("reset_bready", bready, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        aw_delay = 0; w_delay = 0;
        do_arm(32'h7000_0000, 16'd2, 1);
        expect_done(2);
        send_exp(32'h8888_0000, 1'b0);
        send_exp(32'h8888_0001, 1'b0);
        wait_idle();
        check("post_reset_samples", samples_written, 2);

        repeat (3) @(negedge clk);
        check("left_aw", exp_addr.size(), 0);
        check("left_w", exp_data.size(), 0);
        check("left_done", exp_done.size(), 0);
        check("done_pulses", done_seen, done_expected);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
